// File: rtl/module_func_arbiter.sv
// -----------------------------------------------------------------------------
// module_func_arbiter
//
// Round-robin arbiter and sequencer for one shared add-and-decrement unit
// (result = a + b - 1). Requesters offer operands on a valid/ready handshake.
// One requester is granted at a time. Its operands are captured, the result
// is computed in a registered execute stage, and the result is returned with
// the requester ID on a single response channel that supports backpressure.
//
// Ports:
//   in_clk         rising-edge clock
//   in_rst         asynchronous active-high reset
//   in_req_valid   per-requester request valid           [NUM_REQ]
//   in_req_a       packed operand A, requester i at [i*DATA_W +: DATA_W]
//   in_req_b       packed operand B, same packing
//   out_req_ready  one-hot grant (combinational, IDLE only) [NUM_REQ]
//   out_rsp_valid  response valid (RESP state)
//   out_rsp_id     requester index of the response       [ID_W]
//   out_rsp_data   result                                 [DATA_W]
//   in_rsp_ready   consumer accepts the response
//   out_busy       high whenever the FSM is not IDLE
//   out_op_count   completed responses, wraps modulo 2^16
// -----------------------------------------------------------------------------
module module_func_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [NUM_REQ-1:0]        in_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] in_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] in_req_b,
    output logic [NUM_REQ-1:0]        out_req_ready,
    output logic                      out_rsp_valid,
    output logic [ID_W-1:0]           out_rsp_id,
    output logic [DATA_W-1:0]         out_rsp_data,
    input  logic                      in_rsp_ready,
    output logic                      out_busy,
    output logic [15:0]               out_op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [15:0]       op_count_q, op_count_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand_idx;
    int                cand;

    // Round-robin search: starting at rr_ptr and wrapping modulo NUM_REQ,
    // the first requester whose valid is set this cycle wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!grant_found && in_req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // The grant is only offered in IDLE. It is also forced low while reset
    // is asserted so that every output reads 0 during reset, even with
    // requests pending.
    always_comb begin
        out_req_ready = '0;
        if (!in_rst && state_q == IDLE && grant_found) begin
            out_req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Next-state logic. Operands are sampled only at the grant handshake.
    // The result register drops the carry out of the add and the borrow of
    // the decrement.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        result_d   = result_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    a_d      = in_req_a[int'(grant_idx)*DATA_W +: DATA_W];
                    b_d      = in_req_b[int'(grant_idx)*DATA_W +: DATA_W];
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                result_d = a_q + b_q - DATA_W'(1);
                state_d  = RESP;
            end
            RESP: begin
                if (in_rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    // Response side is driven only from registers and state decode, so
    // in_rsp_ready never reaches an output combinationally.
    assign out_rsp_valid = (state_q == RESP);
    assign out_rsp_id    = id_q;
    assign out_rsp_data  = result_q;
    assign out_busy      = (state_q != IDLE);
    assign out_op_count  = op_count_q;

endmodule

// File: tb/tb_module_func_arbiter.sv
module tb_module_func_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    reqValid;
   logic [N*W-1:0]  reqA;
   logic [N*W-1:0]  reqB;
   logic [N-1:0]    reqReady;
   logic            rspValid;
   logic [IW-1:0]   rspId;
   logic [W-1:0]    rspData;
   logic            rspReady;
   logic            busy;
   logic [15:0]     opCount;

   module_func_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .in_clk       (clk),
      .in_rst       (rst),
      .in_req_valid (reqValid),
      .in_req_a     (reqA),
      .in_req_b     (reqB),
      .out_req_ready(reqReady),
      .out_rsp_valid(rspValid),
      .out_rsp_id   (rspId),
      .out_rsp_data (rspData),
      .in_rsp_ready (rspReady),
      .out_busy     (busy),
      .out_op_count (opCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp grants and responses
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard entry: expected response plus the cycle it was granted in
   typedef struct {
      int id;
      int data;
      int gcyc;
      bit seen;
   } exp_t;

   exp_t sb[$];

   // Behavioural model: a pointer saying where the fair search starts, a
   // flag saying a granted job has not yet been accepted, and a count of
   // accepted responses
   int modelPtr    = 0;
   bit outstanding = 1'b0;
   int modelCount  = 0;
   bit rrMode      = 1'b0;
   int lastGrant   = -1;

   int nChecks = 0;
   int nPass   = 0;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nChecks++;
      if (actual == expected) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
   endtask

   // Who should be granted this cycle: nobody while a job is outstanding,
   // otherwise the first valid requester counting up from the pointer
   function automatic int expGrant(input logic [N-1:0] v);
      if (outstanding) return 0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (modelPtr + k) % N;
         if (v[idx]) return (1 << idx);
      end
      return 0;
   endfunction

   // One cycle of stimulus: drive just after the rising edge, check the
   // combinational grant and the status outputs late in the cycle, and
   // record the expected response if the model says a grant happens
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] a,
                                input logic [N*W-1:0] b, input logic r);
      int eg;
      int id;
      int av;
      int bv;
      @(posedge clk);
      #1;
      reqValid = v;
      reqA     = a;
      reqB     = b;
      rspReady = r;
      #3;
      eg = expGrant(v);
      checkOutput("req_ready", reqReady, eg);
      checkOutput("busy", busy, outstanding);
      checkOutput("op_count", opCount, modelCount);
      if (eg != 0) begin
         id = 0;
         for (int k = 0; k < N; k++) if (eg == (1 << k)) id = k;
         av = int'(a[id*W +: W]);
         bv = int'(b[id*W +: W]);
         sb.push_back('{id: id, data: (av + bv + 255) % 256, gcyc: cyc, seen: 1'b0});
         outstanding = 1'b1;
         modelPtr    = (id + 1) % N;
         if (rrMode && lastGrant >= 0) checkOutput("rr_gap", cyc - lastGrant, 3);
         lastGrant = cyc;
      end
   endtask

   // Assert reset in mid-cycle with every input high; all outputs must drop
   // to zero at once and stay there while reset is held
   task automatic applyReset();
      @(posedge clk);
      #2;
      reqValid = '1;
      reqA     = '1;
      reqB     = '1;
      rspReady = 1'b1;
      rst      = 1'b1;
      sb.delete();
      outstanding = 1'b0;
      modelPtr    = 0;
      modelCount  = 0;
      lastGrant   = -1;
      #1;
      checkOutput("rst_req_ready", reqReady, 0);
      checkOutput("rst_rsp_valid", rspValid, 0);
      checkOutput("rst_rsp_id", rspId, 0);
      checkOutput("rst_rsp_data", rspData, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_op_count", opCount, 0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_hold_ready", reqReady, 0);
         checkOutput("rst_hold_valid", rspValid, 0);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      reqValid = '0;
      reqA     = '0;
      reqB     = '0;
   endtask

   // Response monitor: on every falling edge a presented response is
   // compared against the head of the scoreboard (so it must stay stable
   // under backpressure) and popped when the consumer accepts it
   always @(negedge clk) begin
      if (!rst) begin
         if (rspValid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_rsp", rspValid, 0);
            end else begin
               if (!sb[0].seen) begin
                  checkOutput("rsp_latency", cyc - sb[0].gcyc, 2);
                  sb[0].seen = 1'b1;
               end
               checkOutput("rsp_id", rspId, sb[0].id);
               checkOutput("rsp_data", rspData, sb[0].data);
               if (rspReady) begin
                  void'(sb.pop_front());
                  outstanding = 1'b0;
                  modelCount  = (modelCount + 1) % 65536;
               end
            end
         end else if (sb.size() > 0 && (cyc - sb[0].gcyc) > 4) begin
            checkOutput("rsp_timeout", rspValid, 1);
            void'(sb.pop_front());
            outstanding = 1'b0;
         end
      end
   end

   // Operand vector with one requester's a/b set and the others random
   function automatic logic [N*W-1:0] place(input int idx, input logic [W-1:0] val);
      logic [N*W-1:0] vec;
      vec = $urandom;
      vec[idx*W +: W] = val;
      return vec;
   endfunction

   initial begin
      rst      = 1'b1;
      reqValid = '0;
      reqA     = '0;
      reqB     = '0;
      rspReady = 1'b0;

      applyReset();

      // Single request from requester 2: 0x10 + 0x05 - 1 = 0x14
      applyStimulus(4'b0100, place(2, 8'h10), place(2, 8'h05), 1'b1);
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

      // Arithmetic wrap cases on requester 0
      applyStimulus(4'b0001, place(0, 8'hFF), place(0, 8'hFF), 1'b1);
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);
      applyStimulus(4'b0001, place(0, 8'h00), place(0, 8'h00), 1'b1);
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);
      applyStimulus(4'b0001, place(0, 8'h01), place(0, 8'h00), 1'b1);
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

      // Round-robin with everyone continuously valid from a fresh pointer
      applyReset();
      rrMode = 1'b1;
      repeat (18) applyStimulus(4'b1111, $urandom, $urandom, 1'b1);
      rrMode = 1'b0;
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

      // Backpressure: requester 1 stays valid, consumer stalls for 5 RESP
      // cycles, then accepts; requester 1 is granted again right after
      for (int i = 0; i < 11; i++) begin
         applyStimulus(4'b0010, $urandom, $urandom, (i >= 7));
      end
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

      // Reset during EXEC: move the pointer off 0 first, then reset; the
      // next grant with requesters 0 and 3 valid must go to 0
      applyReset();
      applyStimulus(4'b0010, $urandom, $urandom, 1'b1);
      applyReset();
      applyStimulus(4'b1001, $urandom, $urandom, 1'b1);
      repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

      // Randomized traffic with random backpressure
      repeat (400) begin
         applyStimulus(N'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0));
      end

      // Drain and confirm nothing is left waiting
      repeat (6) applyStimulus(4'b0000, '0, '0, 1'b1);
      checkOutput("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
